// File: rtl/vga_plot_arbiter_if.sv
// Plot-port bundle shared between the drawing engines (master) and the
// round-robin arbiter that forwards one engine's pixels to the VGA adapter (slave).
interface vga_plot_arbiter_if #(
  parameter int NREQ = 3
);
  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] req_x;
  logic [7*NREQ-1:0] req_y;
  logic [3*NREQ-1:0] req_colour;
  logic [NREQ-1:0]   req_plot;
  logic [NREQ-1:0]   gnt;
  logic [7:0]        vga_x;
  logic [6:0]        vga_y;
  logic [2:0]        vga_colour;
  logic              vga_plot;
  logic              busy;
  logic [14:0]       pix_count;

  modport master (
    output req, req_x, req_y, req_colour, req_plot,
    input  gnt, vga_x, vga_y, vga_colour, vga_plot, busy, pix_count
  );

  modport slave (
    input  req, req_x, req_y, req_colour, req_plot,
    output gnt, vga_x, vga_y, vga_colour, vga_plot, busy, pix_count
  );
endinterface

// File: rtl/vga_plot_arbiter.sv
// Round-robin owner of the VGA plot port: grants one engine at a time, registers
// its on-screen pixels onto the adapter port and counts them per grant.
module vga_plot_arbiter #(
  parameter int NREQ = 3
) (
  input  logic              clk,
  input  logic              rst,
  vga_plot_arbiter_if.slave bus
);
  localparam int IW = $clog2(NREQ);

  typedef enum logic {IDLE, OWN} state_t;

  state_t          state;
  logic [IW-1:0]   own;
  logic [IW-1:0]   last;
  logic [NREQ-1:0] gnt_q;
  logic [7:0]      x_q;
  logic [6:0]      y_q;
  logic [2:0]      colour_q;
  logic            plot_q;
  logic            busy_q;
  logic [14:0]     count_q;

  logic [IW-1:0]   winner;
  logic [NREQ-1:0] winner_oh;
  logic [7:0]      sel_x;
  logic [6:0]      sel_y;
  logic [2:0]      sel_colour;
  logic            sel_req;
  logic            sel_plot;
  logic            accept;

  // Scan downward from last+NREQ to last+1 so the nearest requester after `last` wins.
  // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
  always_comb begin
    winner    = '0;
    winner_oh = '0;
    for (int k = NREQ; k >= 1; k--) begin
      if (bus.req[(int'(last) + k) % NREQ]) begin
        winner    = IW'((int'(last) + k) % NREQ);
        winner_oh = '0;
        winner_oh[(int'(last) + k) % NREQ] = 1'b1;
      end
    end
  end

  always_comb begin
    sel_x      = '0;
    sel_y      = '0;
    sel_colour = '0;
    sel_req    = 1'b0;
    sel_plot   = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (own == IW'(i)) begin
        sel_x      = bus.req_x[8*i +: 8];
        sel_y      = bus.req_y[7*i +: 7];
        sel_colour = bus.req_colour[3*i +: 3];
        sel_req    = bus.req[i];
        sel_plot   = bus.req_plot[i];
      end
    end
  end

  assign accept = sel_req && sel_plot && (sel_x < 8'd160) && (sel_y < 7'd120);

  // NOTE: sequential state uses non-blocking assignments so every register sees
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      own      <= '0;
      last     <= IW'(NREQ - 1);
      gnt_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
      plot_q   <= 1'b0;
      busy_q   <= 1'b0;
      count_q  <= '0;
    end else begin
      plot_q <= 1'b0;
      case (state)
        IDLE: begin
          if (|bus.req) begin
            own     <= winner;
            gnt_q   <= winner_oh;
            busy_q  <= 1'b1;
            count_q <= '0;
            state   <= OWN;
          end
        end
        OWN: begin
          if (!sel_req) begin
            gnt_q  <= '0;
            busy_q <= 1'b0;
            last   <= own;
            state  <= IDLE;
          end else if (accept) begin
            x_q      <= sel_x;
            y_q      <= sel_y;
            colour_q <= sel_colour;
            plot_q   <= 1'b1;
            if (count_q != 15'h7fff) count_q <= count_q + 15'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt        = gnt_q;
  assign bus.vga_x      = x_q;
  assign bus.vga_y      = y_q;
  assign bus.vga_colour = colour_q;
  assign bus.vga_plot   = plot_q;
  assign bus.busy       = busy_q;
  assign bus.pix_count  = count_q;
endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Directed bench for vga_plot_arbiter: reset, full-screen fill, round-robin order,
// release priority, off-screen drop and mid-stream reset.
module tb_vga_plot_arbiter;
  localparam int NREQ = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests  = 0;
  int   failed = 0;

  vga_plot_arbiter_if #(.NREQ(NREQ)) bus ();

  vga_plot_arbiter #(.NREQ(NREQ)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int i, input int x, input int y, input int c, input logic p);
    bus.req_x[8*i +: 8]      = 8'(x);
    bus.req_y[7*i +: 7]      = 7'(y);
    bus.req_colour[3*i +: 3] = 3'(c);
    bus.req_plot[i]          = p;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_gnt"},   32'(bus.gnt), 32'd0);
    check({tag, "_plot"},  32'(bus.vga_plot), 32'd0);
    check({tag, "_xyc"},   32'({bus.vga_x, bus.vga_y, bus.vga_colour}), 32'd0);
    check({tag, "_busy"},  32'(bus.busy), 32'd0);
    check({tag, "_count"}, 32'(bus.pix_count), 32'd0);
  endtask

  function automatic logic [31:0] pix(input int x, input int y, input int c);
    return 32'({1'b1, 8'(x), 7'(y), 3'(c)});
  endfunction

  initial begin
    // Reset with random inputs
    bus.req        = 3'($urandom);
    bus.req_x      = 24'($urandom);
    bus.req_y      = 21'($urandom);
    bus.req_colour = 9'($urandom);
    bus.req_plot   = 3'($urandom);
    rst = 1'b1;
    tick();
    tick();
    check_reset("reset");
    rst = 1'b0;
    bus.req      = '0;
    bus.req_plot = '0;
    tick();
    check("idle_gnt", 32'(bus.gnt), 32'd0);

    // Single owner full-screen fill, first pixel in the first granted cycle
    bus.req = 3'b001;
    tick();
    check("fill_gnt", 32'(bus.gnt), 32'b001);
    check("fill_busy", 32'(bus.busy), 32'd1);
    check("fill_count0", 32'(bus.pix_count), 32'd0);
    for (int y = 0; y < 120; y++) begin
      for (int x = 0; x < 160; x++) begin
        drive(0, x, y, x % 8, 1'b1);
        tick();
        check("fill_pix", 32'({bus.vga_plot, bus.vga_x, bus.vga_y, bus.vga_colour}),
              pix(x, y, x % 8));
      end
    end
    check("fill_count", 32'(bus.pix_count), 32'd19200);
    bus.req      = 3'b000;
    bus.req_plot = 3'b000;
    tick();
    check("fill_rel_gnt", 32'(bus.gnt), 32'd0);
    check("fill_rel_plot", 32'(bus.vga_plot), 32'd0);
    check("fill_rel_busy", 32'(bus.busy), 32'd0);
    check("fill_rel_count", 32'(bus.pix_count), 32'd19200);

    // Round-robin with all three requesting; each owner releases after 4 pixels
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.req = 3'b111;
    for (int g = 0; g < 4; g++) begin
      int o;
      o = g % 3;
      tick();
      check("rr_gnt", 32'(bus.gnt), 32'(1 << o));
      for (int k = 0; k < 4; k++) begin
        drive(o, o * 10 + k, k, k, 1'b1);
        tick();
        check("rr_pix", 32'({bus.vga_plot, bus.vga_x, bus.vga_y, bus.vga_colour}),
              pix(o * 10 + k, k, k));
      end
      // A pixel offered in the release cycle must be dropped
      drive(o, 100, 100, 7, 1'b1);
      bus.req[o] = 1'b0;
      tick();
      check("rr_dead_gnt", 32'(bus.gnt), 32'd0);
      check("rr_dead_plot", 32'(bus.vga_plot), 32'd0);
      check("rr_count", 32'(bus.pix_count), 32'd4);
      bus.req[o]      = 1'b1;
      bus.req_plot[o] = 1'b0;
    end

    // Priority after release: last = 0, so 1 wins; then 1 releases with 101 -> 2 wins
    bus.req = 3'b010;
    tick();
    check("prio_gnt1", 32'(bus.gnt), 32'b010);
    bus.req = 3'b101;
    tick();
    check("prio_dead", 32'(bus.gnt), 32'd0);
    tick();
    check("prio_gnt2", 32'(bus.gnt), 32'b100);

    // Off-screen drop under owner 2; requester 0 plots too but is not the owner
    drive(2, 160, 5, 1, 1'b1);
    drive(0, 10, 10, 2, 1'b1);
    tick();
    check("off_x_plot", 32'(bus.vga_plot), 32'd0);
    check("off_hold", 32'({bus.vga_x, bus.vga_y, bus.vga_colour}), 32'({8'd3, 7'd3, 3'd3}));
    drive(2, 5, 120, 1, 1'b1);
    tick();
    check("off_y_plot", 32'(bus.vga_plot), 32'd0);
    drive(2, 159, 119, 5, 1'b1);
    tick();
    check("off_edge_pix", 32'({bus.vga_plot, bus.vga_x, bus.vga_y, bus.vga_colour}),
          pix(159, 119, 5));
    bus.req_plot = 3'b000;
    tick();
    check("off_idle_plot", 32'(bus.vga_plot), 32'd0);
    check("off_count", 32'(bus.pix_count), 32'd1);

    // Mid-stream reset on owner 2's 50th accepted pixel
    bus.req = 3'b100;
    for (int k = 0; k < 48; k++) begin
      drive(2, k, 1, 2, 1'b1);
      tick();
    end
    check("mid_count", 32'(bus.pix_count), 32'd49);
    drive(2, 60, 2, 4, 1'b1);
    rst = 1'b1;
    tick();
    check_reset("mid_reset");
    rst = 1'b0;
    bus.req_plot = 3'b000;
    bus.req      = 3'b111;
    tick();
    check("mid_first_gnt", 32'(bus.gnt), 32'b001);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/vga_plot_arbiter.md
# vga_plot_arbiter

Round-robin arbiter that shares the single VGA adapter plot port (x, y, colour, plot) between several pixel-drawing engines (fillscreen, circle, reuleaux). Each engine requests ownership, receives a one-hot grant, and streams pixels while it holds the grant. The arbiter registers the winning pixel onto the adapter port, drops off-screen pixels, and counts the pixels accepted per grant. It sits between the drawing engines and the VGA adapter in the top-level task module.

## Interface
- NREQ, 3: number of requesters (2..8).
- clk  in  1  system clock (CLOCK_50 at top level).
- rst  in  1  synchronous, active-high reset.
- req  in  NREQ  per-requester ownership request; held high for the whole drawing job.
- req_x  in  8*NREQ  packed x coordinate; requester i uses bits [8i+7:8i].
- req_y  in  7*NREQ  packed y coordinate; requester i uses bits [7i+6:7i].
- req_colour  in  3*NREQ  packed colour; requester i uses bits [3i+2:3i].
- req_plot  in  NREQ  per-requester pixel-valid strobe.
- gnt  out  NREQ  one-hot grant (registered).
- vga_x  out  8  registered x to the adapter.
- vga_y  out  7  registered y to the adapter.
- vga_colour  out  3  registered colour to the adapter.
- vga_plot  out  1  registered plot strobe to the adapter.
- busy  out  1  high while any grant is held.
- pix_count  out  15  number of pixels accepted under the current or most recent grant.

## Operation
- There are two states, IDLE and OWN. The arbiter also holds a registered owner index `own` and a last-owner index `last`.
- On reset: state = IDLE, gnt = 0, busy = 0, vga_x = 0, vga_y = 0, vga_colour = 0, vga_plot = 0, pix_count = 0, last = NREQ-1. Index 0 therefore has first priority after reset.
- IDLE behaviour:
  - If req != 0, the arbiter picks the first set req bit searching upward from last+1, with modulo-NREQ wrap.
  - At that edge: own = winner, gnt = one-hot(winner), busy = 1, pix_count = 0, state = OWN.
  - If req == 0, IDLE is held and all outputs keep their values, except that vga_plot = 0.
- OWN behaviour:
  - A pixel is accepted at an edge only if req[own] & req_plot[own] & (x < 160) & (y < 120).
  - On an accepted pixel, vga_x/y/colour are loaded from requester `own`, vga_plot = 1, and pix_count increments. pix_count saturates at 32767.
  - Otherwise vga_plot = 0 and vga_x/y/colour hold their values.
  - Off-screen pixels (x ≥ 160 or y ≥ 120) are dropped silently and are not counted.
- Release: when req[own] is sampled low in OWN, then at that edge gnt = 0, busy = 0, last = own, vga_plot = 0, and state = IDLE.
  - A req_plot[own] that arrives in the same cycle as the release is dropped.
  - pix_count holds its final value until the next grant.
- req_plot from any non-owner is ignored. Requests from non-owners wait; there is no preemption and no timeout.
- A requester that drops req and raises it again re-enters round-robin as a normal requester.
- rst asserted in any state forces the reset values at the next edge. Any in-flight pixel is discarded.

## Timing
- Grant latency: when req rises before edge N in IDLE, gnt is high after edge N.
- Pixel latency is 1 cycle: a req_plot sampled at edge M (while gnt is high) appears on vga_* after edge M.
- A requester may drive its first pixel in the cycle where it first sees gnt high. It may then stream one pixel per cycle with no gaps.
- Every handover has exactly one dead cycle, the IDLE arbitration cycle, during which gnt = 0 and vga_plot = 0.
- A full 160×120 screen streamed back-to-back takes 19200 cycles after the first grant and gives pix_count = 19200.

## Test plan
- Reset check: assert rst for 2 cycles with random inputs -> gnt = 000, vga_plot = 0, vga_x = 0, vga_y = 0, vga_colour = 0, busy = 0, pix_count = 0.
- Single owner full fill: req = 001; requester 0 streams x = 0..159, y = 0..119 with colour = x%8 starting in the first gnt cycle ->
  - every vga_* value matches one cycle later with vga_plot = 1;
  - pix_count = 19200;
  - after req drops: vga_plot = 0 and gnt = 000 one edge later.
- Round-robin: req = 111 held -> grant order 001, 010, 100, 001, with each owner releasing after 4 pixels; each handover shows one cycle of gnt = 000.
- Priority after release: owner 1 releases while req = 101 -> next gnt = 100, not 001.
- Off-screen drop: owner sends (160,5), (5,120), (159,119) -> only (159,119) is plotted; pix_count = 1.
- Mid-operation reset: assert rst on pixel 50 of owner 2 -> all outputs return to reset values next edge. Then with req = 111 after reset, gnt = 001 first.
